// File: rtl/pipe_credit_sink.sv
// rtl/pipe_credit_sink.sv - credit-gated issue and in-order result FIFO for fixed-latency valid-only pipelines
//
// Sits on both ends of a pipeline that cannot stall. Arguments are issued
// only while credits remain. Every result beat is captured into a local
// FIFO without a ready check. Results drain to the consumer over a
// valid/ready stream. A credit returns only when the consumer pops a result,
// so the FIFO cannot overflow while the pipeline returns exactly one result
// per issued argument.
//
// Parameters:
//   WIDTH     result data width
//   DEPTH     FIFO entries (power of two, >= 2); also the total credit count
//
// Ports:
//   clk       clock
//   rst       synchronous, active-high reset
//   up_vld    requester has an argument set to issue
//   up_rdy    issue permitted (credit available); decoded from a register
//   arg_vld   argument valid into the pipeline (up_vld & up_rdy)
//   res_vld   result beat from the pipeline
//   res       result data
//   out_vld   FIFO non-empty
//   out_rdy   consumer accepts the head entry
//   out_data  FIFO head entry (don't-care while out_vld is low)
//   err       sticky protocol error; exists only with PIPE_CREDIT_SINK_ERR_EN
//
// Optional feature macro: PIPE_CREDIT_SINK_ERR_EN
//   When defined, result beats that cannot be legal (nothing in flight, or
//   FIFO full with no same-cycle pop) are dropped and set err until reset.

`timescale 1ns/1ps

module pipe_credit_sink #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_rdy,
    output logic             arg_vld,
    input  logic             res_vld,
    input  logic [WIDTH-1:0] res,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_CREDIT_SINK_ERR_EN
    ,
    output logic             err
`endif
);

    // Counters must hold the value DEPTH itself, pointers only 0..DEPTH-1.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [CW-1:0]    credits;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic issue;
    logic pop;
    logic wr_en;

    // up_rdy depends only on the credit register, so there is no
    // combinational path from out_rdy through to the issue side.
    assign up_rdy   = (credits != '0);
    assign issue    = up_vld & up_rdy;
    assign arg_vld  = issue;

    assign out_vld  = (count != '0);
    assign pop      = out_vld & out_rdy;
    assign out_data = mem[rd_ptr];

`ifdef PIPE_CREDIT_SINK_ERR_EN
    logic beat_bad;

    // A beat with nothing in flight, or one landing on a full FIFO that is
    // not also being popped this cycle, would corrupt state: drop it.
    assign beat_bad = res_vld & ((inflight == '0) | ((count == DEPTH_C) & ~pop));
    assign wr_en    = res_vld & ~beat_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (beat_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign wr_en = res_vld;
`endif

    // Credits: spent on issue, returned on pop; both together cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= DEPTH_C;
        end else if (issue != pop) begin
            credits <= issue ? (credits - CNT_ONE) : (credits + CNT_ONE);
        end
    end

    // Arguments inside the pipeline: issued but not yet returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (issue != wr_en) begin
            inflight <= issue ? (inflight + CNT_ONE) : (inflight - CNT_ONE);
        end
    end

    // FIFO occupancy: write and pop together cancel, even at full or empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_en != pop) begin
            count <= wr_en ? (count + CNT_ONE) : (count - CNT_ONE);
        end
    end

    // Pointers roll over naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= res;
        end
    end

endmodule

// File: tb/tb_pipe_credit_sink.sv
// tb/tb_pipe_credit_sink.sv - scoreboard bench for pipe_credit_sink with a 34-cycle delay-line pipeline

`timescale 1ns/1ps

module tb_pipe_credit_sink;

    localparam int W = 32;
    localparam int L = 34;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- DUT A: DEPTH = 4 ----------------
    logic         a_up_vld, a_up_rdy, a_arg_vld, a_res_vld, a_out_vld, a_out_rdy, a_inj;
    logic [W-1:0] a_res, a_out_data;
`ifdef PIPE_CREDIT_SINK_ERR_EN
    logic         a_err;
`endif

    pipe_credit_sink #(.WIDTH(W), .DEPTH(4)) u_a (
        .clk      (clk),
        .rst      (rst),
        .up_vld   (a_up_vld),
        .up_rdy   (a_up_rdy),
        .arg_vld  (a_arg_vld),
        .res_vld  (a_res_vld),
        .res      (a_res),
        .out_vld  (a_out_vld),
        .out_rdy  (a_out_rdy),
        .out_data (a_out_data)
`ifdef PIPE_CREDIT_SINK_ERR_EN
        ,
        .err      (a_err)
`endif
    );

    // ---------------- DUT B: DEPTH = 64 ----------------
    logic         b_up_vld, b_up_rdy, b_arg_vld, b_res_vld, b_out_vld, b_out_rdy;
    logic [W-1:0] b_res, b_out_data;
`ifdef PIPE_CREDIT_SINK_ERR_EN
    logic         b_err;
`endif

    pipe_credit_sink #(.WIDTH(W), .DEPTH(64)) u_b (
        .clk      (clk),
        .rst      (rst),
        .up_vld   (b_up_vld),
        .up_rdy   (b_up_rdy),
        .arg_vld  (b_arg_vld),
        .res_vld  (b_res_vld),
        .res      (b_res),
        .out_vld  (b_out_vld),
        .out_rdy  (b_out_rdy),
        .out_data (b_out_data)
`ifdef PIPE_CREDIT_SINK_ERR_EN
        ,
        .err      (b_err)
`endif
    );

    // ---------------- pipeline models (identity, latency L) ----------------
    // Argument k (1, 2, 3, ...) comes back as result k; expected results are
    // queued at issue time.
    logic [L-1:0] a_pv, b_pv;
    logic [W-1:0] a_pd [L];
    logic [W-1:0] b_pd [L];
    logic [W-1:0] a_next, b_next;
    logic [W-1:0] a_exp [$];
    logic [W-1:0] b_exp [$];

    always @(posedge clk) begin
        if (rst) begin
            a_pv   <= '0;
            a_next <= 1;
            a_exp.delete();
        end else begin
            a_pv     <= {a_pv[L-2:0], a_arg_vld};
            a_pd[0]  <= a_next;
            for (int i = 1; i < L; i++) a_pd[i] <= a_pd[i-1];
            if (a_arg_vld) begin
                a_next <= a_next + 1;
                a_exp.push_back(a_next);
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            b_pv   <= '0;
            b_next <= 1;
            b_exp.delete();
        end else begin
            b_pv     <= {b_pv[L-2:0], b_arg_vld};
            b_pd[0]  <= b_next;
            for (int i = 1; i < L; i++) b_pd[i] <= b_pd[i-1];
            if (b_arg_vld) begin
                b_next <= b_next + 1;
                b_exp.push_back(b_next);
            end
        end
    end

    assign a_res_vld = a_pv[L-1] | a_inj;
    assign a_res     = a_pd[L-1];
    assign b_res_vld = b_pv[L-1];
    assign b_res     = b_pd[L-1];

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && a_out_vld && a_out_rdy) begin
            if (a_exp.size() == 0) begin
                total++;
                $display("FAIL a_order: got %0h expected nothing", a_out_data);
            end else begin
                check("a_order", a_out_data, a_exp.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_vld && b_out_rdy) begin
            if (b_exp.size() == 0) begin
                total++;
                $display("FAIL b_order: got %0h expected nothing", b_out_data);
            end else begin
                check("b_order", b_out_data, b_exp.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a(input int budget, input string name);
        int n = 0;
        while (a_exp.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        check(name, a_exp.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int hi, first, last, pops;

        rst = 1'b1;
        a_up_vld = 0; a_out_rdy = 0; a_inj = 0;
        b_up_vld = 0; b_out_rdy = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_a_up_rdy", a_up_rdy, 1);
        check("rst_a_out_vld", a_out_vld, 0);
        check("rst_a_arg_vld", a_arg_vld, 0);
        check("rst_b_up_rdy", b_up_rdy, 1);
        check("rst_b_out_vld", b_out_vld, 0);
`ifdef PIPE_CREDIT_SINK_ERR_EN
        check("rst_a_err", a_err, 0);
`endif
        cyc();

        // Back-pressure: four credits only
        for (int c = 0; c < 40; c++) begin
            a_up_vld = 1; a_out_rdy = 0;
            @(negedge clk);
            check($sformatf("bp_arg_vld_c%0d", c), a_arg_vld, (c < 4));
            if (c == 4 || c == 39) check($sformatf("bp_up_rdy_c%0d", c), a_up_rdy, 0);
            if (c == 34) check("bp_out_vld_c34", a_out_vld, 0);
            if (c == 35 || c == 39) check($sformatf("bp_out_vld_c%0d", c), a_out_vld, 1);
            if (c == 39) check("bp_count_full", u_a.count, 4);
            cyc();
        end

        // Drain and credit return
        for (int c = 40; c < 50; c++) begin
            a_up_vld = 1; a_out_rdy = 1;
            @(negedge clk);
            if (c < 44) begin
                check($sformatf("dr_out_vld_c%0d", c), a_out_vld, 1);
                check($sformatf("dr_out_data_c%0d", c), a_out_data, c - 39);
            end
            if (c == 40) check("dr_up_rdy_c40", a_up_rdy, 0);
            if (c == 41) begin
                check("dr_up_rdy_c41", a_up_rdy, 1);
                check("dr_arg_vld_c41", a_arg_vld, 1);
            end
            cyc();
        end
        a_up_vld = 0;
        drain_a(120, "dr_drained");
        check("dr_idle_credits", u_a.credits, 4);
        check("dr_idle_out_vld", a_out_vld, 0);

        // Simultaneous issue and pop with credits=1, count=1
        a_out_rdy = 0; a_up_vld = 1;
        cyc();
        a_up_vld = 0;
        repeat (36) cyc();
        check("sim_setup_count", u_a.count, 1);
        a_up_vld = 1;
        repeat (2) cyc();
        check("sim_setup_credits", u_a.credits, 1);
        a_up_vld = 1; a_out_rdy = 1;
        @(negedge clk);
        check("sim_up_rdy", a_up_rdy, 1);
        check("sim_arg_vld", a_arg_vld, 1);
        check("sim_out_vld", a_out_vld, 1);
        cyc();
        check("sim_credits_kept", u_a.credits, 1);
        check("sim_count_zero", u_a.count, 0);
        check("sim_up_rdy_after", a_up_rdy, 1);
        check("sim_out_vld_after", a_out_vld, 0);
        a_out_rdy = 0;
        cyc();
        check("sim_last_credit_spent", a_up_rdy, 0);
        a_up_vld = 0; a_out_rdy = 1;
        drain_a(120, "sim_drained");

        // Throughput on the 64-deep instance
        b_out_rdy = 1;
        hi = 0; first = -1; last = -1; pops = 0;
        for (int c = 0; c < 150; c++) begin
            b_up_vld = (c < 100);
            @(negedge clk);
            if (c < 100 && b_arg_vld) hi++;
            if (c == 100) check("tp_arg_vld_stop", b_arg_vld, 0);
            if (b_out_vld) begin
                if (first < 0) first = c;
                last = c;
                pops++;
            end
            cyc();
        end
        check("tp_issue_cycles", hi, 100);
        check("tp_first_out", first, 35);
        check("tp_last_out", last, 134);
        check("tp_pops", pops, 100);
        check("tp_drained", b_exp.size(), 0);

`ifdef PIPE_CREDIT_SINK_ERR_EN
        // Protocol error: result beat with nothing in flight
        a_out_rdy = 0;
        a_inj = 1;
        cyc();
        a_inj = 0;
        check("err_set", a_err, 1);
        check("err_count", u_a.count, 0);
        check("err_out_vld", a_out_vld, 0);
        repeat (10) cyc();
        check("err_sticky", a_err, 1);
        rst = 1;
        cyc();
        rst = 0;
        check("err_cleared", a_err, 0);
        check("err_b_clean", b_err, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_credit_sink.md
# pipe_credit_sink

Receive-side terminator for fixed-latency, valid-only arithmetic pipelines (formula pipes built from pipelined isqrt stages). Such pipelines cannot stall, so this block owns the issue side and the result side together. It gates argument issue with a credit counter, captures every `res_vld` beat into an internal FIFO, and presents results to a downstream consumer over a valid/ready stream. It is instantiated between a request source and a pipeline, and between that pipeline and the consumer. Overflow is impossible by construction as long as the pipeline returns exactly one result per issued argument.

## Interface
Parameters:
- `WIDTH`, 32, result data width.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2; also the total credit count.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `up_vld`  in  1  requester has an argument set to issue.
- `up_rdy`  out  1  issue permitted (credit available).
- `arg_vld`  out  1  to pipeline; `up_vld & up_rdy`.
- `res_vld`  in  1  result beat from pipeline.
- `res`  in  WIDTH  result data.
- `out_vld`  out  1  FIFO non-empty.
- `out_rdy`  in  1  consumer accepts head.
- `out_data`  out  WIDTH  FIFO head.
- `err`  out  1  sticky protocol error; present only with `PIPE_CREDIT_SINK_ERR_EN`.

## Operation
- Credit counter `credits`, width `$clog2(DEPTH+1)`:
  - reset value `DEPTH`;
  - issue (`arg_vld`) decrements it;
  - pop (`out_vld & out_rdy`) increments it;
  - issue and pop in the same cycle leave it unchanged.
- Invariant: `credits + inflight + count == DEPTH`.
- `up_rdy = (credits != 0)`. It is a register decode, with no combinational path from `out_rdy`.
- In-flight counter `inflight`:
  - increments on issue;
  - decrements on `res_vld`;
  - both in the same cycle leave it unchanged.
- FIFO:
  - write pointer, read pointer and `count` are all registered;
  - every `res_vld` beat writes `res` at the write pointer, with no ready check;
  - pointers wrap modulo `DEPTH` with natural binary rollover;
  - write and pop in the same cycle leave `count` unchanged, including when `count == DEPTH` or `count == 0`. A same-cycle write into an empty FIFO is not visible that cycle; there is no bypass.
- `out_vld = (count != 0)`. `out_data` is the memory entry at the read pointer. `out_data` is don't-care when `out_vld == 0`.
- Ordering: results leave in arrival order, which equals issue order for an in-order pipeline.
- Dynamic power: FIFO memory is written only on `res_vld`. Pointer and counter registers are enabled only on their events.

## Timing
- Reset values (cycle after `rst` is sampled high): `up_rdy=1`, `arg_vld=up_vld`, `out_vld=0`, `err=0`, `credits=DEPTH`, `inflight=0`, `count=0`, both pointers 0.
- Reset mid-operation:
  - all state returns to the reset values;
  - results still in the pipeline are the pipeline's concern, since its own `rst` clears its valid chain;
  - any `res_vld` beats arriving after reset are written and counted normally.
- `res_vld` at edge N gives `out_vld=1` from cycle N+1.
- Pop at edge N gives a credit visible on `up_rdy` from cycle N+1. Minimum round trip is pipeline latency L + 2 cycles.
- Full throughput (one issue per cycle, sustained) requires `DEPTH ≥ L + 2` with `out_rdy` held high.
- With `credits == 0`, `up_rdy=0` and `arg_vld=0` regardless of `up_vld`.

## Configuration
- `PIPE_CREDIT_SINK_ERR_EN` defined:
  - `err` port exists;
  - `err` sets on `res_vld` while `inflight == 0`, or on a write while `count == DEPTH` and no same-cycle pop;
  - the offending beat is dropped: no write, no counter change;
  - `err` stays high until `rst`.
- Undefined:
  - no `err` port and no check logic;
  - a protocol violation is undefined behaviour.

## Test plan
Bench pipeline model: delay line with L=34, `DEPTH=4` unless stated.
- Reset: hold `rst` 2 cycles, release → `up_rdy=1`, `out_vld=0`, `err=0`.
- Back-pressure: `up_vld=1` continuous, `out_rdy=0` → exactly 4 `arg_vld` pulses on cycles 0..3, `up_rdy=0` from cycle 4. Results 1,2,3,4 arrive on cycles 34..37. `out_vld=1` from cycle 35. `up_rdy` stays 0 and there is no overflow.
- Drain and credit return: continue the previous case, set `out_rdy=1` at cycle 40 → `out_data` sequence 1,2,3,4 on cycles 40..43. `up_rdy=1` at cycle 41, and a new issue on cycle 41.
- Throughput (`DEPTH=64`): 100 back-to-back issues, `out_rdy=1` → `arg_vld` high 100 consecutive cycles, 100 in-order outputs starting at cycle 35.
- Simultaneous issue and pop: hold `credits=1` with `count=1`, `up_vld=1`, `out_rdy=1` in the same cycle → `credits` stays 1, `count` drops to 0, `up_rdy` stays 1.
- Error (macro defined): force `res_vld=1` with nothing issued → `err=1` next cycle, `count` stays 0, `err` is still 1 after 10 cycles and clears only on `rst`.
